// File: rtl/mschd_pkg.sv
// Shared definitions for the SHA-256 message-schedule controller.
// Optional abort input is enabled with MSCHD_CTRL_ABORT_EN (see mschd_ctrl).
package mschd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } mschd_state_e;

    localparam int SHA256_ROUNDS = 64;
    localparam int SCHED_WORDS   = 16;
    localparam int WORD_W        = 32;

endpackage : mschd_pkg

// File: rtl/mschd_rnd_cnt.sv
// Round counter for the message schedule: holds t, the index of the word
// currently on m0, and flags the last round (t == ROUNDS-1).
// clr has priority over inc.
module mschd_rnd_cnt #(
    parameter int ROUNDS = 64,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] t,
    output logic             last
);

    logic [IDX_W-1:0] t_q;
    logic [IDX_W-1:0] t_d;

    // Next-count selection: clear wins, otherwise step on inc, else hold.
    always_comb begin
        t_d = t_q;
        if (clr) begin
            t_d = {IDX_W{1'b0}};
        end else if (inc) begin
            t_d = t_q + IDX_W'(1);
        end else begin
            t_d = t_q;
        end
    end

    // Count register, cleared asynchronously on reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            t_q <= {IDX_W{1'b0}};
        end else begin
            t_q <= t_d;
        end
    end

    assign t    = t_q;
    assign last = (t_q == IDX_W'(ROUNDS - 1));

endmodule : mschd_rnd_cnt

// File: rtl/mschd_ctrl.sv
// SHA-256 message-schedule controller: accepts a block, steps the schedule
// datapath through ROUNDS words under round-unit backpressure, then pulses done.
// Optional feature: define MSCHD_CTRL_ABORT_EN to add the abort input, which
// returns the controller to IDLE without a done pulse.
module mschd_ctrl
    import mschd_pkg::*;
#(
    parameter int ROUNDS = SHA256_ROUNDS,
    parameter int IDX_W  = 6
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             blk_vld,
    output logic             blk_rdy,
    output logic             ld_mreg,
    output logic             upd_mreg,
    input  logic             rnd_rdy,
`ifdef MSCHD_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             w_vld,
    output logic [IDX_W-1:0] w_idx,
    output logic             done,
    output logic             busy
);

    mschd_state_e     state_q;
    mschd_state_e     state_d;
    logic             cnt_clr_s;
    logic             cnt_inc_s;
    logic             cnt_last_s;
    logic [IDX_W-1:0] cnt_t_s;
    logic             ld_s;
    logic             upd_s;
    logic             abort_s;

    logic             blk_rdy_q;
    logic             w_vld_q;
    logic             done_q;
    logic             busy_q;

`ifdef MSCHD_CTRL_ABORT_EN
    assign abort_s = abort;
`else
    assign abort_s = 1'b0;
`endif

    mschd_rnd_cnt #(
        .ROUNDS (ROUNDS),
        .IDX_W  (IDX_W)
    ) u_rnd_cnt (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (cnt_clr_s),
        .inc    (cnt_inc_s),
        .t      (cnt_t_s),
        .last   (cnt_last_s)
    );

    // Next state, counter control and the combinational datapath strobes.
    always_comb begin
        state_d   = state_q;
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        ld_s      = 1'b0;
        upd_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Datapath loads the block on the same edge that accepts it.
                ld_s  = blk_vld;
                upd_s = blk_vld;
                if (blk_vld) begin
                    state_d   = ST_RUN;
                    cnt_clr_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                // Schedule shifts only when the round unit takes the word.
                upd_s = rnd_rdy;
                if (rnd_rdy) begin
                    if (cnt_last_s) begin
                        state_d   = ST_DONE;
                        cnt_clr_s = 1'b1;
                    end else begin
                        cnt_inc_s = 1'b1;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_clr_s = 1'b1;
            end
        endcase
        // Abort overrides every other request in any state.
        if (abort_s) begin
            state_d   = ST_IDLE;
            cnt_clr_s = 1'b1;
            cnt_inc_s = 1'b0;
            ld_s      = 1'b0;
            upd_s     = 1'b0;
        end else begin
            cnt_inc_s = cnt_inc_s;
        end
    end

    // State register plus outputs registered from the next state so they
    // are glitch-free and aligned with the state they describe.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= ST_IDLE;
            blk_rdy_q <= 1'b1;
            w_vld_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_rdy_q <= (state_d == ST_IDLE);
            w_vld_q   <= (state_d == ST_RUN);
            done_q    <= (state_d == ST_DONE);
            busy_q    <= (state_d == ST_RUN) || (state_d == ST_DONE);
        end
    end

    // Abort in IDLE withholds the ready indication for that cycle.
    assign blk_rdy  = blk_rdy_q & ~abort_s;
    assign ld_mreg  = ld_s;
    assign upd_mreg = upd_s;
    assign w_vld    = w_vld_q;
    assign w_idx    = cnt_t_s;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule : mschd_ctrl

// File: tb/tb_mschd_ctrl.sv
// Directed bench for mschd_ctrl: a per-cycle vector table for the start of a
// block, then hand-written sequences for full runs, backpressure, held
// blk_vld, reset in mid-run and (when enabled) abort.
module tb_mschd_ctrl;

    localparam int ROUNDS = 64;
    localparam int IDX_W  = 6;

    logic             clk;
    logic             rst_b;
    logic             blk_vld;
    logic             blk_rdy;
    logic             ld_mreg;
    logic             upd_mreg;
    logic             rnd_rdy;
    logic             abort;
    logic             w_vld;
    logic [IDX_W-1:0] w_idx;
    logic             done;
    logic             busy;

    int n_cmp;
    int n_err;

    mschd_ctrl #(
        .ROUNDS   (ROUNDS),
        .IDX_W    (IDX_W)
    ) dut (
        .clk      (clk),
        .rst_b    (rst_b),
        .blk_vld  (blk_vld),
        .blk_rdy  (blk_rdy),
        .ld_mreg  (ld_mreg),
        .upd_mreg (upd_mreg),
        .rnd_rdy  (rnd_rdy),
`ifdef MSCHD_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .w_vld    (w_vld),
        .w_idx    (w_idx),
        .done     (done),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             blk_vld;
        logic             rnd_rdy;
        logic             blk_rdy;
        logic             ld_mreg;
        logic             upd_mreg;
        logic             w_vld;
        logic [IDX_W-1:0] w_idx;
        logic             done;
        logic             busy;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Idle-state outputs (reset values) except for the ld/upd strobes.
    task automatic chk_idle(input string name);
        chk({name, ".blk_rdy"}, {31'd0, blk_rdy}, 32'd1);
        chk({name, ".w_vld"},   {31'd0, w_vld},   32'd0);
        chk({name, ".w_idx"},   {26'd0, w_idx},   32'd0);
        chk({name, ".done"},    {31'd0, done},    32'd0);
        chk({name, ".busy"},    {31'd0, busy},    32'd0);
    endtask

    function automatic logic pat(input int mode, input int cyc);
        if (mode == 0) return 1'b1;
        return ((cyc % 4) == 0) || ((cyc % 4) == 3);
    endfunction

    // Accept cycle: controller in IDLE, block offered.
    task automatic accept();
        @(negedge clk);
        blk_vld = 1'b1;
        rnd_rdy = 1'b0;
        abort   = 1'b0;
        #1;
        chk("acc.blk_rdy", {31'd0, blk_rdy}, 32'd1);
        chk("acc.ld",      {31'd0, ld_mreg}, 32'd1);
        chk("acc.upd",     {31'd0, upd_mreg}, 32'd1);
        chk("acc.busy",    {31'd0, busy},    32'd0);
    endtask

    // Present words start_t..stop_t-1 in RUN; returns cycles used.
    task automatic run_words(input int start_t, input int stop_t, input logic hold,
                             input int mode, output int cyc);
        int t;
        t   = start_t;
        cyc = 0;
        while (t < stop_t && cyc < 1000) begin
            @(negedge clk);
            blk_vld = hold;
            rnd_rdy = pat(mode, cyc);
            #1;
            chk("run.w_vld",   {31'd0, w_vld},    32'd1);
            chk("run.w_idx",   {26'd0, w_idx},    t);
            chk("run.upd",     {31'd0, upd_mreg}, {31'd0, rnd_rdy});
            chk("run.ld",      {31'd0, ld_mreg},  32'd0);
            chk("run.blk_rdy", {31'd0, blk_rdy},  32'd0);
            chk("run.done",    {31'd0, done},     32'd0);
            chk("run.busy",    {31'd0, busy},     32'd1);
            if (rnd_rdy) t++;
            cyc++;
        end
        if (t < stop_t) chk("run.timeout", t, stop_t);
    endtask

    // DONE cycle, then the first IDLE cycle with blk_vld = hold.
    task automatic done_phase(input logic hold);
        @(negedge clk);
        blk_vld = hold;
        rnd_rdy = 1'b1;
        #1;
        chk("dn.done",    {31'd0, done},     32'd1);
        chk("dn.busy",    {31'd0, busy},     32'd1);
        chk("dn.w_vld",   {31'd0, w_vld},    32'd0);
        chk("dn.blk_rdy", {31'd0, blk_rdy},  32'd0);
        chk("dn.upd",     {31'd0, upd_mreg}, 32'd0);
        chk("dn.ld",      {31'd0, ld_mreg},  32'd0);
        @(negedge clk);
        blk_vld = hold;
        rnd_rdy = 1'b0;
        #1;
        chk_idle("post");
        chk("post.ld",  {31'd0, ld_mreg},  {31'd0, hold});
        chk("post.upd", {31'd0, upd_mreg}, {31'd0, hold});
    endtask

    initial begin
        int cyc;
        n_cmp   = 0;
        n_err   = 0;
        rst_b   = 1'b0;
        blk_vld = 1'b0;
        rnd_rdy = 1'b0;
        abort   = 1'b0;

        // Per-cycle table for the start of a block (from IDLE).
        //          vld  rdy  brdy ld   upd  wv   idx    done busy
        vecs[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd1, 1'b0, 1'b1};
        vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6'd2, 1'b0, 1'b1};
        vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd2, 1'b0, 1'b1};
        vecs[8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'd3, 1'b0, 1'b1};

        // Reset held across several edges, released mid-cycle.
        repeat (3) @(posedge clk);
        #1;
        chk_idle("rst.hold");
        chk("rst.ld",  {31'd0, ld_mreg},  32'd0);
        chk("rst.upd", {31'd0, upd_mreg}, 32'd0);
        @(negedge clk);
        #2 rst_b = 1'b1;
        #1;
        chk_idle("rst.rel");

        // Table-driven start of block 1 (ends with t=4 registered).
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            blk_vld = vecs[i].blk_vld;
            rnd_rdy = vecs[i].rnd_rdy;
            #1;
            chk($sformatf("v%0d.blk_rdy", i), {31'd0, blk_rdy},  {31'd0, vecs[i].blk_rdy});
            chk($sformatf("v%0d.ld", i),      {31'd0, ld_mreg},  {31'd0, vecs[i].ld_mreg});
            chk($sformatf("v%0d.upd", i),     {31'd0, upd_mreg}, {31'd0, vecs[i].upd_mreg});
            chk($sformatf("v%0d.w_vld", i),   {31'd0, w_vld},    {31'd0, vecs[i].w_vld});
            chk($sformatf("v%0d.w_idx", i),   {26'd0, w_idx},    {26'd0, vecs[i].w_idx});
            chk($sformatf("v%0d.done", i),    {31'd0, done},     {31'd0, vecs[i].done});
            chk($sformatf("v%0d.busy", i),    {31'd0, busy},     {31'd0, vecs[i].busy});
        end
        run_words(4, ROUNDS, 1'b0, 0, cyc);
        chk("blk1.cycles", cyc, 60);
        done_phase(1'b0);

        // Full block with rnd_rdy held high: one word per cycle.
        accept();
        run_words(0, ROUNDS, 1'b0, 0, cyc);
        chk("full.cycles", cyc, ROUNDS);
        done_phase(1'b0);

        // Backpressure 1,0,0,1: two words per four cycles.
        accept();
        run_words(0, ROUNDS, 1'b0, 1, cyc);
        chk("bp.cycles", cyc, 2 * ROUNDS);
        done_phase(1'b0);

        // blk_vld held high: reload only at the first IDLE cycle after DONE.
        accept();
        run_words(0, ROUNDS, 1'b1, 0, cyc);
        done_phase(1'b1);
        run_words(0, ROUNDS, 1'b0, 0, cyc);
        chk("hold2.cycles", cyc, ROUNDS);
        done_phase(1'b0);

        // Reset pulse while w_idx=30: outputs drop asynchronously.
        accept();
        run_words(0, 30, 1'b0, 0, cyc);
        @(negedge clk);
        rnd_rdy = 1'b1;
        #1;
        chk("mid.w_idx", {26'd0, w_idx}, 32'd30);
        #2 rst_b = 1'b0;
        #1;
        chk_idle("mid.rst");
        rnd_rdy = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst_b = 1'b1;
        accept();
        run_words(0, ROUNDS, 1'b0, 0, cyc);
        chk("mid.restart", cyc, ROUNDS);
        done_phase(1'b0);

`ifdef MSCHD_CTRL_ABORT_EN
        // Abort at w_idx=10: straight back to IDLE, no done pulse.
        accept();
        run_words(0, 10, 1'b0, 0, cyc);
        @(negedge clk);
        abort   = 1'b1;
        rnd_rdy = 1'b1;
        #1;
        chk("ab.upd",   {31'd0, upd_mreg}, 32'd0);
        chk("ab.w_idx", {26'd0, w_idx},    32'd10);
        @(negedge clk);
        abort   = 1'b0;
        rnd_rdy = 1'b0;
        #1;
        chk_idle("ab.idle");
        // Abort in IDLE masks ready and the load strobes.
        @(negedge clk);
        abort   = 1'b1;
        blk_vld = 1'b1;
        #1;
        chk("abi.blk_rdy", {31'd0, blk_rdy},  32'd0);
        chk("abi.ld",      {31'd0, ld_mreg},  32'd0);
        chk("abi.upd",     {31'd0, upd_mreg}, 32'd0);
        @(negedge clk);
        abort   = 1'b0;
        blk_vld = 1'b0;
        #1;
        chk_idle("abi.after");
        accept();
        run_words(0, ROUNDS, 1'b0, 0, cyc);
        done_phase(1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_mschd_ctrl
